des_expand_mix: RTL
===================

# des_expand_mix

Upstream stage of the DES round datapath: accepts the 32-bit right half R and the 48-bit round subkey K, and computes the DES E-expansion E(R) XOR K. It presents the result as eight 6-bit groups B1..B8 that drive the eight S-box ROMs directly. The block is pipelined behind a valid/ready handshake, with a one-entry skid buffer so that it sustains one word per clock under backpressure.

## Interface
Parameters: none (all widths fixed by DES).

- CLK  input  1  sole clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- R_IN  input  [32:1]  right half; DES bit n = R_IN[33-n]
- K_IN  input  [48:1]  subkey; DES bit n = K_IN[49-n]
- IN_VALID  input  1  R_IN/K_IN valid
- IN_READY  output  1  block can accept; transfer when IN_VALID & IN_READY
- B_OUT  output  [48:1]  E(R) XOR K; group Bk = B_OUT[54-6k : 49-6k] (B1 = [48:43], B8 = [6:1]); group bit 6 is its first DES bit, matching S-box input [6:1]
- OUT_VALID  output  1  B_OUT valid
- OUT_READY  input  1  consumer accepts; transfer when OUT_VALID & OUT_READY
- TAG_IN  input  [4:1]  round tag (only with DES_EXPAND_TAG_EN)
- TAG_OUT  output  [4:1]  tag aligned with B_OUT (only with DES_EXPAND_TAG_EN)

## Operation
- Expansion: group k (1..8) takes DES R bits 4k-4, 4k-3, 4k-2, 4k-1, 4k, 4k+1, in that order. Bit 0 maps to 32 and bit 33 maps to 1. The result is XORed bitwise with K.
- E(R) XOR K is computed combinationally at the input and captured into a register; nothing combinational follows the registers on B_OUT.
- Storage: main register M (drives B_OUT/OUT_VALID) and skid register S (with S_VALID).
- IN_READY = !S_VALID, taken directly from a register.
- Per cycle, with accept = IN_VALID & IN_READY and pop = OUT_VALID & OUT_READY:
  - M empty or pop, with S_VALID: M <= S, S_VALID <= 0. A new accept in the same cycle goes to S (S_VALID stays 1).
  - M empty or pop, with !S_VALID: on accept, M <= new word; otherwise OUT_VALID <= 0.
  - M full and !pop: an accept goes to S and S_VALID <= 1.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- B_OUT and TAG_OUT stay stable while OUT_VALID & !OUT_READY.

## Timing
- Reset values: OUT_VALID=0, B_OUT=0, TAG_OUT=0, S_VALID=0, so IN_READY=1 from the first cycle after RST is released.
- RST asserted mid-operation clears M and S on that edge and discards in-flight words.
- While RST is high, IN_READY=0 and inputs are ignored.
- Latency: a word accepted at edge t appears with OUT_VALID=1 in the cycle after edge t (1 cycle), provided M is empty or popping.
- Throughput: 1 word per cycle with OUT_READY held high.
- Full condition: M and S both occupied. IN_READY=0 until the next pop.
- Simultaneous accept and pop with S empty: the new word goes to M and throughput is maintained.
- OUT_READY may be asserted with OUT_VALID=0; this has no effect.

## Configuration
- DES_EXPAND_TAG_EN defined: TAG_IN/TAG_OUT ports exist. The tag is captured with its word and moves with it through M and S.
- Macro undefined: the tag ports, and all registers behind them, are absent.
- The data path and timing are identical in both cases.

## Test plan
- Known vector: R_IN=F0AAF0AA, K_IN=1B02EFFC7072 -> B_OUT=6117BA866527 one cycle after accept. B4=111010, which makes S4 output 2.
- Wrap bits: R_IN=80000001, K_IN=0 -> B_OUT=C00000000003 (B1=110000, B8=000011).
- Backpressure: stream words 1,2,3 with OUT_READY=0 -> word 1 held in M, word 2 in S, IN_READY=0 and word 3 stalled. Raising OUT_READY then delivers 1,2,3 in order on consecutive cycles.
- Full throughput: 8 back-to-back words with OUT_READY=1 -> 8 consecutive OUT_VALID cycles, none lost.
- Reset mid-stream: RST asserted with M and S full -> next cycle OUT_VALID=0 and B_OUT=0; IN_READY=1 after release; stale words never appear.
- With DES_EXPAND_TAG_EN: tags 1..4 sent under random OUT_READY -> TAG_OUT matches each B_OUT word's tag.

Source files
------------

// File: rtl/des_expand_mix.sv
// Purpose : DES round front end, registers E(R) XOR K as eight 6-bit S-box groups B1..B8.
// Latency : 1 cycle from accept to OUT_VALID when the main register is empty or popping.
// Backpr. : main + one-entry skid register; IN_READY (registered) drops only when both are full.
//
// Ports:
//   CLK, RST              sole clock; synchronous active-high reset
//   R_IN[32:1]            right half, DES bit n = R_IN[33-n]
//   K_IN[48:1]            round subkey, DES bit n = K_IN[49-n]
//   IN_VALID / IN_READY   input handshake
//   B_OUT[48:1]           E(R) XOR K, group Bk = B_OUT[54-6k:49-6k] (B1 at the top)
//   OUT_VALID / OUT_READY output handshake
//   TAG_IN / TAG_OUT      4-bit round tag carried with each word
//                         (present only when DES_EXPAND_TAG_EN is defined)

module des_expand_mix (
  input  logic        CLK,
  input  logic        RST,
  input  logic [32:1] R_IN,
  input  logic [48:1] K_IN,
  input  logic        IN_VALID,
  output logic        IN_READY,
`ifdef DES_EXPAND_TAG_EN
  input  logic [4:1]  TAG_IN,
  output logic [4:1]  TAG_OUT,
`endif
  output logic [48:1] B_OUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  // ---------------------------------------------------------------------------
  // E-expansion: pure wiring. Output DES bit m = 6(k-1)+j sits at B index
  // 49-m = 55-6k-j and takes DES R bit 4k-5+j, with 0 -> 32 and 33 -> 1.
  // ---------------------------------------------------------------------------
  logic [48:1] e_r;
  logic [48:1] exp_xor_k;

  for (genvar k = 1; k <= 8; k++) begin : g_grp
    for (genvar j = 1; j <= 6; j++) begin : g_bit
      localparam int DRAW = 4 * k - 5 + j;
      localparam int DBIT = (DRAW == 0) ? 32 : ((DRAW == 33) ? 1 : DRAW);
      assign e_r[55 - 6 * k - j] = R_IN[33 - DBIT];
    end
  end

  assign exp_xor_k = e_r ^ K_IN;

  // ---------------------------------------------------------------------------
  // Main (M) and skid (S) registers
  // ---------------------------------------------------------------------------
  logic        m_vld_q, m_vld_d;
  logic [48:1] m_dat_q, m_dat_d;
  logic        s_vld_q, s_vld_d;
  logic [48:1] s_dat_q, s_dat_d;
  // Held low through reset so the upstream never sees a ready block while RST is high.
  logic        rdy_q,   rdy_d;

  logic accept;
  logic pop;
  logic m_free;
  logic m_load_s;
  logic m_load_in;
  logic s_load_in;

  assign accept = IN_VALID & rdy_q;
  assign pop    = m_vld_q & OUT_READY;
  assign m_free = ~m_vld_q | pop;

  always_comb begin
    m_load_s  = 1'b0;
    m_load_in = 1'b0;
    s_load_in = 1'b0;
    m_vld_d   = m_vld_q;
    s_vld_d   = s_vld_q;

    if (m_free) begin
      if (s_vld_q) begin
        // Skid word moves forward; a concurrent accept refills the skid.
        m_load_s  = 1'b1;
        m_vld_d   = 1'b1;
        s_load_in = accept;
        s_vld_d   = accept;
      end else begin
        // Empty skid: new word goes straight to M, keeping full throughput.
        m_load_in = accept;
        m_vld_d   = accept;
      end
    end else if (accept) begin
      // M stalled: park the new word in the skid.
      s_load_in = 1'b1;
      s_vld_d   = 1'b1;
    end

    rdy_d = ~s_vld_d;
  end

  always_comb begin
    m_dat_d = m_dat_q;
    s_dat_d = s_dat_q;
    if (m_load_s) begin
      m_dat_d = s_dat_q;
    end else if (m_load_in) begin
      m_dat_d = exp_xor_k;
    end
    if (s_load_in) begin
      s_dat_d = exp_xor_k;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
      s_vld_q <= 1'b0;
      s_dat_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
      s_vld_q <= s_vld_d;
      s_dat_q <= s_dat_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef DES_EXPAND_TAG_EN
  // Tags follow exactly the same load decisions as the data words.
  logic [4:1] m_tag_q, m_tag_d;
  logic [4:1] s_tag_q, s_tag_d;

  always_comb begin
    m_tag_d = m_tag_q;
    s_tag_d = s_tag_q;
    if (m_load_s) begin
      m_tag_d = s_tag_q;
    end else if (m_load_in) begin
      m_tag_d = TAG_IN;
    end
    if (s_load_in) begin
      s_tag_d = TAG_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_tag_q <= '0;
      s_tag_q <= '0;
    end else begin
      m_tag_q <= m_tag_d;
      s_tag_q <= s_tag_d;
    end
  end

  assign TAG_OUT = m_tag_q;
`endif

  assign B_OUT     = m_dat_q;
  assign OUT_VALID = m_vld_q;
  assign IN_READY  = rdy_q;

endmodule
